// File: rtl/square_if.sv
`default_nettype none
// ============================================================================
// Module   : square_if
// Purpose  : Operand/handshake/result bundle for the sequential squarer.
// Revision : 1.0 - initial release
// ============================================================================
interface square_if #(
    parameter int N = 4
);
    logic [N-1:0]   x_in;
    logic           start_in;
    logic           busy_out;
    logic [2*N-1:0] y_out;

    modport master (output x_in, output start_in, input  busy_out, input  y_out);
    modport slave  (input  x_in, input  start_in, output busy_out, output y_out);
endinterface
`default_nettype wire

// File: rtl/square.sv
`default_nettype none
// ============================================================================
// Module   : square
// Purpose  : Shift-and-add unsigned squarer, one multiplier bit per cycle.
//            Optional macro SQUARE_EARLY_EXIT_EN ends the operation as soon as
//            the remaining multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
module square #(
    parameter int N = 4
) (
    input  wire logic clk_in,
    input  wire logic rst_in,
    square_if.slave   bus
);
    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WORK = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] y_q, y_d;
    logic           early_exit;
    logic           finish;

`ifdef SQUARE_EARLY_EXIT_EN
    assign early_exit = (mplier_q == '0);
`else
    assign early_exit = 1'b0;
`endif

    assign finish = (state_q == WORK) && ((cnt_q == '0) || early_exit);

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_in) state_d = WORK;
            WORK:    if (finish)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: busy decoded straight from the state register
    always_comb begin
        bus.busy_out = (state_q == WORK);
        bus.y_out    = y_q;
    end

    // Datapath next-state
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        if (state_q == IDLE) begin
            if (bus.start_in) begin
                mcand_d  = {{N{1'b0}}, bus.x_in};
                mplier_d = bus.x_in;
                acc_d    = '0;
                cnt_d    = CW'(N);
            end
        end else if (finish) begin
            y_d = acc_q;
        end else begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= CW'(N);
            y_q      <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_square.sv
`default_nettype none
// ============================================================================
// Module   : tb_square
// Purpose  : Directed self-checking bench for square (N=4), scoreboard based.
// Revision : 1.0 - initial release
// ============================================================================
module tb_square;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    square_if #(.N(N)) bus ();

    square #(.N(N)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned exp_q[$];

    function automatic int exp_busy(input int x);
`ifdef SQUARE_EARLY_EXIT_EN
        int h;
        if (x == 0) return 1;
        h = 0;
        for (int i = 0; i < N; i++) if (x[i]) h = i;
        return h + 2;
`else
        return N + 1;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts busy cycles from the current negedge until busy falls, then pops
    // the scoreboard and compares y_out.
    task automatic wait_done(input int x, input int y_before, input int already);
        int cycles;
        int exp;
        cycles = already;
        while (bus.busy_out === 1'b1 && cycles < 200) begin
            check("y_stable_while_busy", int'(bus.y_out), y_before);
            cycles++;
            @(negedge clk);
        end
        check($sformatf("busy_len_x%0d", x), cycles, exp_busy(x));
        check("scoreboard_nonempty", int'(exp_q.size() > 0), 1);
        exp = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
        check($sformatf("y_x%0d", x), int'(bus.y_out), exp);
    endtask

    task automatic run_op(input int x);
        int y_prev;
        @(negedge clk);
        y_prev       = int'(bus.y_out);
        bus.x_in     = N'(x);
        bus.start_in = 1'b1;
        exp_q.push_back(x * x);
        @(negedge clk);
        bus.start_in = 1'b0;
        bus.x_in     = N'($urandom);
        wait_done(x, y_prev, 0);
    endtask

    initial begin
        int y_prev;
        bus.x_in     = '0;
        bus.start_in = 1'b0;

        // Reset state, visible without any clock edge
        #1;
        check("reset_busy", int'(bus.busy_out), 0);
        check("reset_y", int'(bus.y_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(15);
        run_op(9);
        run_op(0);
        for (int x = 0; x < 16; x++) run_op(x);

        // Start and operand changes during WORK are ignored
        @(negedge clk);
        y_prev       = int'(bus.y_out);
        bus.x_in     = N'(3);
        bus.start_in = 1'b1;
        exp_q.push_back(9);
        @(negedge clk);
        bus.start_in = 1'b0;
        @(negedge clk);
        bus.start_in = 1'b1;
        bus.x_in     = N'(15);
        @(negedge clk);
        @(negedge clk);
        bus.start_in = 1'b0;
        wait_done(3, y_prev, 3);
        repeat (2) begin
            @(negedge clk);
            check("no_second_op", int'(bus.busy_out), 0);
        end

        // Asynchronous reset aborts an operation in flight
        run_op(9);
        @(negedge clk);
        bus.x_in     = N'(15);
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        @(negedge clk);
        check("busy_before_abort", int'(bus.busy_out), 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy_out), 0);
        check("abort_y", int'(bus.y_out), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(2);

        // Back-to-back with start held high
        @(negedge clk);
        y_prev       = int'(bus.y_out);
        bus.x_in     = N'(7);
        bus.start_in = 1'b1;
        exp_q.push_back(49);
        @(negedge clk);
        wait_done(7, y_prev, 0);
        exp_q.push_back(49);
        @(negedge clk);
        check("b2b_accepted", int'(bus.busy_out), 1);
        bus.start_in = 1'b0;
        wait_done(7, 49, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
